// File: rtl/stream_seq_checker.sv
// stream_seq_checker: valid/ready sink that checks beats against an incrementing
// sequence, counts mismatches, flags handshake violations and applies LFSR stalls.
module stream_seq_checker #(
    parameter int          DATA_WIDTH = 32,
    parameter int          CNT_WIDTH  = 32,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  num_items_i,
    input  logic                  stall_en_i,
    input  logic [3:0]            stall_thresh_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  rcv_count_o,
    output logic [CNT_WIDTH-1:0]  err_count_o,
    output logic                  err_o,
    output logic [CNT_WIDTH-1:0]  first_err_idx_o,
    output logic [DATA_WIDTH-1:0] first_err_data_o,
    output logic                  proto_err_o
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    logic [1:0]            state;
    logic [CNT_WIDTH-1:0]  num_items, rcv_count, err_count, first_err_idx;
    logic [DATA_WIDTH-1:0] expected, first_err_data, prev_data;
    logic [15:0]           lfsr;
    logic                  err, proto_err, pend, ready, accept, launch, mismatch;
    always_comb begin
        ready    = (state == RUN) && !(stall_en_i && lfsr[3:0] < stall_thresh_i);
        accept   = valid_i && ready;
        launch   = start_i && state != RUN;
        mismatch = data_i != expected;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state          <= IDLE;
            num_items      <= '0;
            rcv_count      <= '0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            expected       <= '0;
            prev_data      <= '0;
            lfsr           <= LFSR_SEED;
            err            <= 1'b0;
            proto_err      <= 1'b0;
            pend           <= 1'b0;
        end else if (launch) begin
            state          <= num_items_i == '0 ? DONE : RUN;
            num_items      <= num_items_i;
            rcv_count      <= '0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            expected       <= '0;
            prev_data      <= '0;
            lfsr           <= LFSR_SEED;
            err            <= 1'b0;
            proto_err      <= 1'b0;
            pend           <= 1'b0;
        end else if (state == RUN) begin
            lfsr      <= lfsr[0] ? (lfsr >> 1) ^ 16'hB400 : lfsr >> 1;
            // pend remembers a stalled offer that must be held unchanged
            pend      <= valid_i && !ready;
            prev_data <= data_i;
            if (pend && (!valid_i || data_i != prev_data))
                proto_err <= 1'b1;
            if (accept) begin
                rcv_count <= rcv_count + CNT_WIDTH'(1);
                expected  <= expected + DATA_WIDTH'(1);
                if (mismatch && err_count != '1)
                    err_count <= err_count + CNT_WIDTH'(1);
                if (mismatch && !err) begin
                    err            <= 1'b1;
                    first_err_idx  <= rcv_count;
                    first_err_data <= data_i;
                end
                if (rcv_count + CNT_WIDTH'(1) == num_items)
                    state <= DONE;
            end
        end
    end
    assign ready_o          = ready;
    assign busy_o           = state == RUN;
    assign done_o           = state == DONE;
    assign rcv_count_o      = rcv_count;
    assign err_count_o      = err_count;
    assign err_o            = err;
    assign first_err_idx_o  = first_err_idx;
    assign first_err_data_o = first_err_data;
    assign proto_err_o      = proto_err;
endmodule

// File: tb/tb_stream_seq_checker.sv
// tb_stream_seq_checker: directed stimulus with a per-cycle reference model for the
// 32-bit instance and literal checks, plus a 4-bit instance for sequence wrap.
module tb_stream_seq_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst_n, start, start_w, stall_en, valid, chk_on;
    logic [3:0]  thresh;
    logic [31:0] num_items, data;
    logic        ready_d, busy_d, done_d, err_d, perr_d;
    logic [31:0] rcv_d, errc_d, fidx_d, fdata_d;
    logic        ready_w, busy_w, done_w, err_w, perr_w;
    logic [31:0] rcv_w, errc_w, fidx_w;
    logic [3:0]  fdata_w;
    int compared = 0, mismatched = 0;

    stream_seq_checker dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .num_items_i(num_items),
        .stall_en_i(stall_en), .stall_thresh_i(thresh), .valid_i(valid), .data_i(data),
        .ready_o(ready_d), .busy_o(busy_d), .done_o(done_d), .rcv_count_o(rcv_d),
        .err_count_o(errc_d), .err_o(err_d), .first_err_idx_o(fidx_d),
        .first_err_data_o(fdata_d), .proto_err_o(perr_d)
    );
    stream_seq_checker #(.DATA_WIDTH(4)) dut_w (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_w), .num_items_i(num_items),
        .stall_en_i(stall_en), .stall_thresh_i(thresh), .valid_i(valid), .data_i(data[3:0]),
        .ready_o(ready_w), .busy_o(busy_w), .done_o(done_w), .rcv_count_o(rcv_w),
        .err_count_o(errc_w), .err_o(err_w), .first_err_idx_o(fidx_w),
        .first_err_data_o(fdata_w), .proto_err_o(perr_w)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? (s >> 1) ^ 16'hB400 : s >> 1;
    endfunction

    // reference model of the 32-bit instance: 0 idle, 1 run, 2 done
    int          m_phase = 0;
    logic [31:0] m_n = 0, m_rcv = 0, m_errc = 0, m_fidx = 0, m_fdata = 0, m_exp = 0, m_pdata = 0;
    logic [15:0] m_lfsr = 16'hACE1;
    bit          m_erf = 0, m_perr = 0, m_pend = 0, mr;

    function automatic bit m_ready();
        return m_phase == 1 && !(stall_en && m_lfsr[3:0] < thresh);
    endfunction

    task automatic m_clear();
        m_rcv = 0; m_errc = 0; m_fidx = 0; m_fdata = 0; m_exp = 0; m_pdata = 0;
        m_lfsr = 16'hACE1; m_erf = 0; m_perr = 0; m_pend = 0;
    endtask

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_clear(); m_phase = 0; m_n = 0;
        end else if (m_phase != 1 && start) begin
            m_clear(); m_n = num_items; m_phase = num_items == 0 ? 2 : 1;
        end else if (m_phase == 1) begin
            mr = m_ready();
            if (m_pend && (!valid || data != m_pdata)) m_perr = 1;
            m_pend = valid && !mr;
            m_pdata = data;
            if (valid && mr) begin
                if (data != m_exp) begin
                    if (m_errc != 32'hFFFF_FFFF) m_errc++;
                    if (!m_erf) begin m_erf = 1; m_fidx = m_rcv; m_fdata = data; end
                end
                m_exp++;
                m_rcv++;
                if (m_rcv == m_n) m_phase = 2;
            end
            m_lfsr = lfsr_step(m_lfsr);
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("ready", 64'(ready_d), 64'(m_ready()));
            chk("busy", 64'(busy_d), 64'(m_phase == 1));
            chk("done", 64'(done_d), 64'(m_phase == 2));
            chk("rcv_count", 64'(rcv_d), 64'(m_rcv));
            chk("err_count", 64'(errc_d), 64'(m_errc));
            chk("err", 64'(err_d), 64'(m_erf));
            chk("first_err_idx", 64'(fidx_d), 64'(m_fidx));
            chk("first_err_data", 64'(fdata_d), 64'(m_fdata));
            chk("proto_err", 64'(perr_d), 64'(m_perr));
        end
    end

    // compliant source: holds data while stalled; stop >= 0 abandons the run early
    task automatic run(input bit w, input int n, input int stop, input int bad1, input int bad2,
                       output int edges, output int rdy_hi, output int stalls);
        int idx;
        bit acc;
        idx = 0; rdy_hi = 0; stalls = 0;
        num_items = n;
        valid = 1'b1;
        data = (bad1 == 0 || bad2 == 0) ? 32'hDEAD_BEEF : 32'd0;
        if (w) start_w = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start_w = 1'b0;
        edges = 1;
        while (idx < n && idx != stop && edges < 20000) begin
            @(negedge clk);
            acc = w ? ready_w : ready_d;
            if (acc) rdy_hi++; else stalls++;
            @(posedge clk); #1;
            edges++;
            if (acc) begin
                idx++;
                data = (idx == bad1 || idx == bad2) ? 32'hDEAD_BEEF : 32'(idx);
            end
        end
        valid = 1'b0;
        if (edges >= 20000) begin
            compared++; mismatched++;
            $display("FAIL run_timeout: %0d of %0d beats accepted", idx, n);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0; valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    int e, r, s;
    initial begin
        rst_n = 1'b0; start = 1'b0; start_w = 1'b0; stall_en = 1'b0; thresh = 4'd0;
        valid = 1'b0; data = 32'd0; num_items = 32'd0; chk_on = 1'b0;
        @(posedge clk); #1;
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(ready_d), 64'd0);
        chk("rst_busy", 64'(busy_d), 64'd0);
        chk("rst_rcv", 64'(rcv_d), 64'd0);
        rst_n = 1'b1;

        run(0, 8, -1, -1, -1, e, r, s);
        chk("clean_edges_to_done", 64'(e), 64'd9);
        chk("clean_ready_cycles", 64'(r), 64'd8);
        @(negedge clk);
        chk("clean_rcv", 64'(rcv_d), 64'd8);
        chk("clean_errc", 64'(errc_d), 64'd0);
        chk("clean_done", 64'(done_d), 64'd1);
        chk("clean_ready_after", 64'(ready_d), 64'd0);

        run(0, 10, -1, 3, 7, e, r, s);
        @(negedge clk);
        chk("bad_errc", 64'(errc_d), 64'd2);
        chk("bad_fidx", 64'(fidx_d), 64'd3);
        chk("bad_fdata", 64'(fdata_d), 64'hDEAD_BEEF);
        chk("bad_err", 64'(err_d), 64'd1);
        chk("bad_rcv", 64'(rcv_d), 64'd10);

        stall_en = 1'b1; thresh = 4'd8;
        run(0, 1000, -1, -1, -1, e, r, s);
        chk("bp_stalled", 64'(s > 0), 64'd1);
        @(negedge clk);
        chk("bp_rcv", 64'(rcv_d), 64'd1000);
        chk("bp_errc", 64'(errc_d), 64'd0);
        chk("bp_proto", 64'(perr_d), 64'd0);

        // LFSR nibbles after start are 1 then 0, so both cycles stall at thresh 15
        thresh = 4'd15; num_items = 4; valid = 1'b1; data = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("pv_stalled", 64'(ready_d), 64'd0);
        @(posedge clk); #1;
        data = 32'd6;
        @(negedge clk);
        chk("pv_no_err_yet", 64'(perr_d), 64'd0);
        @(posedge clk); #1;
        chk("pv_data_change", 64'(perr_d), 64'd1);
        chk("pv_errc", 64'(errc_d), 64'd0);
        pulse_reset();
        valid = 1'b1; data = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        valid = 1'b0;
        @(posedge clk); #1;
        chk("pv_valid_drop", 64'(perr_d), 64'd1);
        chk("pv_rcv", 64'(rcv_d), 64'd0);
        pulse_reset();

        stall_en = 1'b0; thresh = 4'd0;
        run(0, 10, 4, -1, -1, e, r, s);
        chk("rr_partial", 64'(rcv_d), 64'd4);
        pulse_reset();
        @(negedge clk);
        chk("rr_rcv", 64'(rcv_d), 64'd0);
        chk("rr_busy", 64'(busy_d), 64'd0);
        chk("rr_done", 64'(done_d), 64'd0);
        run(0, 3, -1, -1, -1, e, r, s);
        @(negedge clk);
        chk("rr2_rcv", 64'(rcv_d), 64'd3);
        chk("rr2_errc", 64'(errc_d), 64'd0);
        chk("rr2_done", 64'(done_d), 64'd1);

        run(1, 20, -1, -1, -1, e, r, s);
        @(negedge clk);
        chk("wrap_rcv", 64'(rcv_w), 64'd20);
        chk("wrap_errc", 64'(errc_w), 64'd0);
        chk("wrap_err", 64'(err_w), 64'd0);
        chk("wrap_fidx", 64'(fidx_w), 64'd0);
        chk("wrap_fdata", 64'(fdata_w), 64'd0);
        chk("wrap_done", 64'(done_w), 64'd1);
        chk("wrap_proto", 64'(perr_w), 64'd0);
        run(1, 0, -1, -1, -1, e, r, s);
        @(negedge clk);
        chk("zero_done", 64'(done_w), 64'd1);
        chk("zero_ready", 64'(ready_w), 64'd0);
        chk("zero_busy", 64'(busy_w), 64'd0);
        chk("zero_rcv", 64'(rcv_w), 64'd0);
        run(0, 0, -1, -1, -1, e, r, s);
        @(negedge clk);
        chk("zero32_done", 64'(done_d), 64'd1);
        chk("zero32_ready", 64'(ready_d), 64'd0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
